// File: rtl/xst_pkg.sv
// rtl/xst_pkg.sv - shared widths, mark constant and state type for the serial transmit/receive pair
package xst_pkg;

  localparam int DAT_W  = 64;
  localparam int BITS_W = 6;
  localparam int BAUD_W = 64;

  localparam logic [DAT_W-1:0] MARK = '1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } xst_state_e;

endpackage

// File: rtl/xst_baud.sv
// rtl/xst_baud.sv - reload down-counter producing one tick per (div+1) clocks while running
module xst_baud #(
  parameter int W = 64
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         start_i,
  input  logic         run_i,
  input  logic [W-1:0] div_i,
  output logic         tick_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] div_q;

  assign tick_o = run_i && (cnt_q == '0);

  // The divisor is latched at start so later changes on div_i cannot
  // stretch or shrink bit times of the frame in flight.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      cnt_q <= '0;
      div_q <= '0;
    end else if (start_i) begin
      cnt_q <= div_i;
      div_q <= div_i;
    end else if (run_i) begin
      if (cnt_q == '0) cnt_q <= div_q;
      else             cnt_q <= cnt_q - W'(1);
    end
  end

endmodule

// File: rtl/xst.sv
// rtl/xst.sv - serial transmit shift register, bit time from internal divisor or external txc_i edges
module xst #(
  parameter int DAT_W  = xst_pkg::DAT_W,
  parameter int BITS_W = xst_pkg::BITS_W,
  parameter int BAUD_W = xst_pkg::BAUD_W
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [BITS_W-1:0] bits_i,
  input  logic [BAUD_W-1:0] baud_i,
  input  logic [DAT_W-1:0]  dat_i,
  input  logic              txreg_we_i,
  input  logic              txc_i,
  output logic              txd_o,
  output logic              idle_o,
  output logic              shift_o
);
  import xst_pkg::*;

  xst_state_e        state_q, state_d;
  logic [DAT_W-1:0]  shreg_q;
  logic [BITS_W-1:0] bit_cnt_q;
  logic              shift_q;
  logic              txc_s1_q, txc_s2_q, txc_s3_q;
  logic              load, do_shift, baud_tick, ext_edge, idle;

  assign idle     = (state_q == ST_IDLE);
  assign load     = idle && txreg_we_i && (bits_i != '0);
  assign ext_edge = txc_s2_q && !txc_s3_q;
  // A coincident baud tick and external edge still produce a single shift.
  assign do_shift = !idle && (baud_tick || ext_edge);

  xst_baud #(.W(BAUD_W)) u_baud (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .start_i (load),
    .run_i   (!idle),
    .div_i   (baud_i),
    .tick_o  (baud_tick)
  );

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (load) state_d = ST_SEND;
      ST_SEND: if (do_shift && bit_cnt_q == BITS_W'(1)) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      shreg_q   <= '1;
      bit_cnt_q <= '0;
      shift_q   <= 1'b0;
      txc_s1_q  <= 1'b0;
      txc_s2_q  <= 1'b0;
      txc_s3_q  <= 1'b0;
    end else begin
      txc_s1_q <= txc_i;
      txc_s2_q <= txc_s1_q;
      txc_s3_q <= txc_s2_q;
      shift_q  <= do_shift;
      if (load) begin
        shreg_q   <= dat_i;
        bit_cnt_q <= bits_i;
      end else if (do_shift) begin
        // Ones fill from the top so the line rests at mark after the frame.
        shreg_q   <= {1'b1, shreg_q[DAT_W-1:1]};
        bit_cnt_q <= bit_cnt_q - BITS_W'(1);
      end
    end
  end

  assign txd_o   = shreg_q[0];
  assign idle_o  = idle;
  assign shift_o = shift_q;

endmodule

// File: tb/tb_xst.sv
// tb/tb_xst.sv - directed self-checking bench for the xst serial transmitter
module tb_xst;
  import xst_pkg::*;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [5:0]  bits_i;
  logic [63:0] baud_i;
  logic [63:0] dat_i;
  logic        txreg_we_i;
  logic        txc_i;
  logic        txd_o;
  logic        idle_o;
  logic        shift_o;

  int n_pass  = 0;
  int n_chk   = 0;
  int n_shift = 0;

  xst dut (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .bits_i     (bits_i),
    .baud_i     (baud_i),
    .dat_i      (dat_i),
    .txreg_we_i (txreg_we_i),
    .txc_i      (txc_i),
    .txd_o      (txd_o),
    .idle_o     (idle_o),
    .shift_o    (shift_o)
  );

  always #10 clk_i = ~clk_i;

  always @(negedge clk_i) if (shift_o) n_shift++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Called 5 ns after a rising edge; returns 5 ns after the load edge.
  task automatic do_load(input logic [5:0] bits, input logic [63:0] baud, input logic [63:0] dat);
    bits_i     = bits;
    baud_i     = baud;
    dat_i      = dat;
    txreg_we_i = 1'b1;
    @(posedge clk_i);
    #5;
    txreg_we_i = 1'b0;
  endtask

  task automatic run_8o1(input bit busy);
    logic [10:0] exp_bits;
    exp_bits = 11'h6AA;
    do_load(6'd11, 64'd49, {{53{1'b1}}, 11'h6AA});
    for (int cyc = 0; cyc <= 550; cyc++) begin
      if (cyc > 0) begin
        @(posedge clk_i);
        #5;
      end
      if (cyc < 550 && (cyc % 50 == 0 || cyc % 50 == 49))
        check($sformatf("txd_8o1_c%0d", cyc), 64'(txd_o), 64'(exp_bits[cyc / 50]));
      if (cyc == 49) check("shift_before_first", 64'(shift_o), 64'd0);
      if (cyc == 50) check("shift_first", 64'(shift_o), 64'd1);
      if (cyc == 549) check("idle_549", 64'(idle_o), 64'd0);
      if (cyc == 550) begin
        check("idle_550", 64'(idle_o), 64'd1);
        check("txd_after_8o1", 64'(txd_o), 64'd1);
      end
      if (busy && cyc == 175) begin
        txreg_we_i = 1'b1;
        dat_i      = '0;
        bits_i     = 6'd11;
        baud_i     = '0;
      end
      if (busy && cyc == 176) txreg_we_i = 1'b0;
    end
  endtask

  initial begin
    int base;
    reset_i    = 1'b0;
    txc_i      = 1'b0;
    txreg_we_i = 1'b0;
    bits_i     = '0;
    baud_i     = '0;
    dat_i      = '0;
    repeat (2) @(posedge clk_i);
    #5;
    check("rst_txd", 64'(txd_o), 64'd1);
    check("rst_idle", 64'(idle_o), 64'd1);
    check("rst_shift", 64'(shift_o), 64'd0);
    reset_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #5;
    check("post_rst_txd", 64'(txd_o), 64'd1);
    check("post_rst_idle", 64'(idle_o), 64'd1);

    do_load(6'd0, 64'd0, 64'd0);
    check("zero_bits_idle", 64'(idle_o), 64'd1);
    check("zero_bits_txd", 64'(txd_o), 64'd1);
    @(posedge clk_i);
    #5;
    check("zero_bits_idle_later", 64'(idle_o), 64'd1);

    run_8o1(1'b0);
    run_8o1(1'b1);

    do_load(6'd3, 64'd0, {{60{1'b1}}, 4'hA});
    check("fast_txd0", 64'(txd_o), 64'd0);
    check("fast_idle0", 64'(idle_o), 64'd0);
    @(posedge clk_i); #5;
    check("fast_txd1", 64'(txd_o), 64'd1);
    check("fast_idle1", 64'(idle_o), 64'd0);
    @(posedge clk_i); #5;
    check("fast_txd2", 64'(txd_o), 64'd0);
    check("fast_idle2", 64'(idle_o), 64'd0);
    @(posedge clk_i); #5;
    check("fast_idle3", 64'(idle_o), 64'd1);
    check("fast_txd3", 64'(txd_o), 64'd1);

    do_load(6'd11, '1, {{53{1'b1}}, 11'h000});
    base = n_shift;
    check("ext_txd0", 64'(txd_o), 64'd0);
    for (int p = 1; p <= 11; p++) begin
      txc_i = 1'b1;
      #500;
      txc_i = 1'b0;
      #500;
      check($sformatf("ext_shifts_p%0d", p), 64'(n_shift - base), 64'(p));
      check($sformatf("ext_idle_p%0d", p), 64'(idle_o), 64'(p == 11));
      check($sformatf("ext_txd_p%0d", p), 64'(txd_o), 64'(p == 11));
    end

    do_load(6'd11, 64'd49, {{53{1'b1}}, 11'h6AA});
    repeat (210) @(posedge clk_i);
    #5;
    check("mid_txd_bit4", 64'(txd_o), 64'd0);
    #1 reset_i = 1'b0;
    #1;
    check("mid_rst_txd", 64'(txd_o), 64'd1);
    check("mid_rst_idle", 64'(idle_o), 64'd1);
    check("mid_rst_shift", 64'(shift_o), 64'd0);
    @(posedge clk_i);
    #5 reset_i = 1'b1;
    @(posedge clk_i);
    #5;
    run_8o1(1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
